// File: rtl/mod_choice_majority_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_choice_majority_counter
//  Purpose  : SHA-256 round helper. Provides the combinational Ch(e,f,g) and
//             Maj(a,b,c) functions and a free-running address counter. The
//             counter indexes the message schedule, K constants or H values.
//
//  Ports    : CLK  in   1       rising-edge clock for the counter
//             RST  in   1       synchronous, active-high reset (counter only)
//             E    in   DATA_W  choice selector word
//             F    in   DATA_W  choice word taken where E bit = 1
//             G    in   DATA_W  choice word taken where E bit = 0
//             A    in   DATA_W  majority operand a
//             B    in   DATA_W  majority operand b
//             C    in   DATA_W  majority operand c
//             CH   out  DATA_W  Ch(E,F,G), combinational
//             MAJ  out  DATA_W  Maj(A,B,C), combinational
//             CNT  out  CNT_W   registered address count
//
//  Options  : MOD_COUNTER_SAT_EN  when defined, CNT saturates at its all-ones
//                                 value instead of wrapping to zero.
//
//  Revision : 1.0  initial release
// ============================================================================
module mod_choice_majority_counter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] E,
    input  logic [DATA_W-1:0] F,
    input  logic [DATA_W-1:0] G,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] C,
    output logic [DATA_W-1:0] CH,
    output logic [DATA_W-1:0] MAJ,
    output logic [CNT_W-1:0]  CNT
);

    logic [DATA_W-1:0] w_ch;
    logic [DATA_W-1:0] w_maj;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [CNT_W-1:0]  w_cnt_d;

    // Bitwise Ch and Maj. Each bit is independent, so the functions are
    // expressed per bit; the XOR forms are the textbook SHA-256 definitions.
    generate
        for (genvar i = 0; i < DATA_W; i++) begin : g_bit
            assign w_ch[i]  = (E[i] & F[i]) ^ (~E[i] & G[i]);
            assign w_maj[i] = (A[i] & B[i]) ^ (A[i] & C[i]) ^ (B[i] & C[i]);
        end
    endgenerate

    assign CH  = w_ch;
    assign MAJ = w_maj;

    // Next-count selection. Reset priority is applied in the register below.
`ifdef MOD_COUNTER_SAT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    always_comb begin
        w_cnt_d = r_cnt_q + CNT_W'(1);
        if (r_cnt_q == c_CNT_MAX) begin
            w_cnt_d = r_cnt_q;
        end
    end
`else
    // Natural modulo-2^CNT_W wrap from the adder overflow.
    always_comb begin
        w_cnt_d = r_cnt_q + CNT_W'(1);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign CNT = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_choice_majority_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_choice_majority_counter
//  Purpose  : Self-checking bench for mod_choice_majority_counter: fixed
//             vectors for Ch/Maj, directed counter sequences (reset, count,
//             mid-count reset, wrap or saturation), and randomized stimulus
//             compared against a behavioural model.
//  Options  : MOD_COUNTER_SAT_EN selects the saturating-counter expectation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_choice_majority_counter;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK;
    logic              RST;
    logic [DATA_W-1:0] E, F, G, A, B, C;
    logic [DATA_W-1:0] CH, MAJ;
    logic [CNT_W-1:0]  CNT;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    mod_choice_majority_counter #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .E  (E),
        .F  (F),
        .G  (G),
        .A  (A),
        .B  (B),
        .C  (C),
        .CH (CH),
        .MAJ(MAJ),
        .CNT(CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [DATA_W-1:0] e, f, g, a, b, c;
        logic [DATA_W-1:0] ch, maj;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference Ch: each result bit picks F where E is set, else G.
    function automatic logic [DATA_W-1:0] ref_ch(input logic [DATA_W-1:0] e,
                                                 input logic [DATA_W-1:0] f,
                                                 input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = e[i] ? f[i] : g[i];
        return r;
    endfunction

    // Reference Maj: a result bit is set when at least two of the three are.
    function automatic logic [DATA_W-1:0] ref_maj(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] r;
        int ones;
        for (int i = 0; i < DATA_W; i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (ones >= 2);
        end
        return r;
    endfunction

    // Advance one rising edge, update the counter model from the value of
    // RST seen at that edge, then settle 1 time unit before any checking.
    task automatic tick();
        logic rst_at_edge;
        @(posedge CLK);
        rst_at_edge = RST;
        #1;
        if (rst_at_edge) begin
            exp_cnt = 0;
        end else begin
`ifdef MOD_COUNTER_SAT_EN
            if (exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
`else
            exp_cnt = (exp_cnt + 1) % (CNT_MAX + 1);
`endif
        end
    endtask

    task automatic rand_ops();
        E = $urandom; F = $urandom; G = $urandom;
        A = $urandom; B = $urandom; C = $urandom;
    endtask

    vec_t vecs[5];

    initial begin
        RST = 1'b1;
        E = '0; F = '0; G = '0; A = '0; B = '0; C = '0;

        vecs[0] = '{32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0,
                    32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0,
                    32'hFF00F0F0, 32'hFFF0F000};
        vecs[1] = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'h01234567,
                    32'h12345678, 32'h12345678, 32'h00000000,
                    32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{32'h00000000, 32'hDEADBEEF, 32'h01234567,
                    32'h12345678, 32'h12345678, 32'hFFFFFFFF,
                    32'h01234567, 32'h12345678};
        vecs[3] = '{32'h0F0F0F0F, 32'hAAAAAAAA, 32'h55555555,
                    32'h00000000, 32'h00000000, 32'hFFFFFFFF,
                    32'h5A5A5A5A, 32'h00000000};
        vecs[4] = '{32'hAAAAAAAA, 32'h00000000, 32'hFFFFFFFF,
                    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                    32'h55555555, 32'hFFFFFFFF};

        // Two reset edges; counter must read zero.
        tick();
        tick();
        chk("cnt_reset", 64'(CNT), 64'(0));

        // Table-driven combinational vectors (CH/MAJ need no clock).
        for (int i = 0; i < 5; i++) begin
            E = vecs[i].e; F = vecs[i].f; G = vecs[i].g;
            A = vecs[i].a; B = vecs[i].b; C = vecs[i].c;
            #1;
            chk($sformatf("ch_vec%0d", i),  64'(CH),  64'(vecs[i].ch));
            chk($sformatf("maj_vec%0d", i), 64'(MAJ), 64'(vecs[i].maj));
        end

        // Release reset: 0 is visible, then 1..9 on consecutive edges.
        @(negedge CLK);
        RST = 1'b0;
        chk("cnt_pre_count", 64'(CNT), 64'(0));
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("cnt_seq%0d", k), 64'(CNT), 64'(k));
        end

        // Mid-count reset clears at the next edge.
        RST = 1'b1;
        tick();
        chk("cnt_midreset", 64'(CNT), 64'(0));
        RST = 1'b0;

        // 256 edges from zero: wraps to 0, or saturates at the maximum.
        for (int k = 0; k < CNT_MAX + 1; k++) begin
            tick();
            if (k == CNT_MAX - 1) chk("cnt_at_max", 64'(CNT), 64'(CNT_MAX));
        end
`ifdef MOD_COUNTER_SAT_EN
        chk("cnt_256_sat", 64'(CNT), 64'(CNT_MAX));
        for (int k = 0; k < 5; k++) tick();
        chk("cnt_sat_hold", 64'(CNT), 64'(CNT_MAX));
`else
        chk("cnt_256_wrap", 64'(CNT), 64'(0));
        for (int k = 0; k < 5; k++) tick();
        chk("cnt_after_wrap", 64'(CNT), 64'(5));
`endif
        // Reset clears from a saturated or arbitrary value.
        RST = 1'b1;
        tick();
        chk("cnt_reset_again", 64'(CNT), 64'(0));

        // Held reset with random operands: counter stays 0, functions track.
        for (int k = 0; k < 20; k++) begin
            rand_ops();
            tick();
            chk("hold_cnt", 64'(CNT), 64'(0));
            chk("hold_ch",  64'(CH),  64'(ref_ch(E, F, G)));
            chk("hold_maj", 64'(MAJ), 64'(ref_maj(A, B, C)));
        end

        // Fully random run with occasional resets against the model.
        for (int k = 0; k < 600; k++) begin
            rand_ops();
            RST = ($urandom_range(0, 15) == 0);
            tick();
            chk("rand_cnt", 64'(CNT), 64'(exp_cnt));
            chk("rand_ch",  64'(CH),  64'(ref_ch(E, F, G)));
            chk("rand_maj", 64'(MAJ), 64'(ref_maj(A, B, C)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_choice_majority_counter.md
MOD_CHOICE_MAJORITY_COUNTER -- requirements
Module: mod_choice_majority_counter

Interface
REQ-001 Parameter DATA_W, default 32, width of the choice and majority operands and results.
REQ-002 Parameter CNT_W, default 8, width of the address counter.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 E  input  DATA_W  choice selector word (SHA-256 working variable e).
REQ-006 F  input  DATA_W  choice word taken where E bit = 1.
REQ-007 G  input  DATA_W  choice word taken where E bit = 0.
REQ-008 A  input  DATA_W  majority operand (working variable a).
REQ-009 B  input  DATA_W  majority operand (working variable b).
REQ-010 C  input  DATA_W  majority operand (working variable c).
REQ-011 CH  output  DATA_W  Ch(E,F,G) result, combinational.
REQ-012 MAJ  output  DATA_W  Maj(A,B,C) result, combinational.
REQ-013 CNT  output  CNT_W  registered address count (message/K or H-value address).

Function
REQ-014 CH SHALL equal (E AND F) XOR ((NOT E) AND G), bitwise over all DATA_W bits.
REQ-015 MAJ SHALL equal (A AND B) XOR (A AND C) XOR (B AND C), bitwise over all DATA_W bits.
REQ-016 CH and MAJ SHALL be purely combinational: no clock, no reset dependency, zero-cycle latency, no latches.
REQ-017 CNT SHALL be a register updated only on the rising edge of CLK.
REQ-018 At a rising edge with RST=0, CNT SHALL become CNT+1 modulo 2^CNT_W, unless overridden by REQ-024.
REQ-019 At a rising edge with RST=1, CNT SHALL become 0; RST takes priority over counting.
REQ-020 On the first rising edge after RST falls, CNT SHALL go from 0 to 1, so a user sampling on the falling edge sees 0,1,2,... on consecutive cycles.
REQ-021 Without REQ-024, CNT SHALL wrap from 2^CNT_W-1 to 0 (255 -> 0 for CNT_W=8) and keep counting.
REQ-022 Asserting RST mid-count SHALL clear CNT at the next rising edge regardless of its value.

Reset
REQ-023 Reset SHALL be synchronous and active-high. CNT resets to 0. CH and MAJ are unaffected by reset.

Configuration
REQ-024 When macro MOD_COUNTER_SAT_EN is defined, CNT SHALL hold at 2^CNT_W-1 instead of wrapping. RST still clears it to 0. When the macro is undefined, CNT wraps per REQ-021. No other behaviour differs.

Verification
REQ-025 E=FFFF0000, F=FF00FF00, G=F0F0F0F0 -> CH=FF00F0F0. E=FFFFFFFF -> CH=F. E=00000000 -> CH=G.
REQ-026 A=FFFF0000, B=FF00FF00, C=F0F0F0F0 -> MAJ=FFF0F000. A=B=12345678 with any C -> MAJ=12345678.
REQ-027 RST=1 for 2 edges, then RST=0 for 9 edges -> CNT sequence 0,1,2,...,9. Re-assert RST at CNT=9 -> CNT=0 at the next edge.
REQ-028 Count from 0 for 256 edges with RST=0 -> without MOD_COUNTER_SAT_EN, CNT=0 (wrapped). With the macro, CNT reaches 255 and stays at 255 for further edges.
REQ-029 Hold RST=1 while toggling E/F/G/A/B/C randomly -> CNT stays 0, and CH/MAJ match the REQ-014/015 formulas every cycle.
